// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial add sequencer.
package add_seq_pkg;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } add_seq_state_t;
endpackage

// File: rtl/add_seq_ctrl_add4_slice.sv
// Combinational 4-bit ripple-carry adder slice shared by every nibble of an operation.
module add4_slice
    import add_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] ina,
    input  logic [NIBBLE_W-1:0] inb,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);
    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i] = ina[i] ^ inb[i] ^ c;
            c      = (ina[i] & inb[i]) | (c & (ina[i] ^ inb[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/add_seq_ctrl.sv
// Valid/ready sequencer running a DATA_W-bit add one nibble per clock through one add4_slice.
// Optional subtract mode (req_sub port) is enabled by defining ADD_SEQ_SUB_EN.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic              req_sub,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_cout,
    output logic              busy
);
    localparam int NIB   = DATA_W / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    if ((DATA_W % NIBBLE_W) != 0 || DATA_W < 8) begin : g_bad_width
        $error("add_seq_ctrl: DATA_W must be a multiple of 4 and >= 8");
    end

    add_seq_state_t state, state_next;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic [DATA_W-1:0]   a_reg, b_reg;
    logic                accept, step, last;
    logic                carry_init;
    logic [NIBBLE_W-1:0] nib_a, nib_b, slice_b, slice_sum;
    logic                slice_cout;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                accept     = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (idx == IDX_LAST) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtract is A + ~B + 1: invert B per nibble and force the initial carry.
`ifdef ADD_SEQ_SUB_EN
    logic sub_reg;

    always_ff @(posedge clk) begin
        if (accept) sub_reg <= req_sub;
    end

    assign slice_b    = nib_b ^ {NIBBLE_W{sub_reg}};
    assign carry_init = req_sub ? 1'b1 : req_cin;
`else
    assign slice_b    = nib_b;
    assign carry_init = req_cin;
`endif

    // Operands only matter from accept onward, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= req_a;
            b_reg <= req_b;
        end
    end

    assign nib_a = a_reg[NIBBLE_W*idx +: NIBBLE_W];
    assign nib_b = b_reg[NIBBLE_W*idx +: NIBBLE_W];

    add4_slice u_slice (
        .ina  (nib_a),
        .inb  (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            carry   <= carry_init;
            rsp_sum <= '0;
        end else if (step) begin
            rsp_sum[NIBBLE_W*idx +: NIBBLE_W] <= slice_sum;
            carry <= slice_cout;
            if (last) begin
                rsp_cout <= slice_cout;
                idx      <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: vector table, multi-cycle corner sequences, randomized ops vs arithmetic model.
module tb_add_seq_ctrl;
    localparam int DATA_W = 16;
    localparam int NIB    = DATA_W / 4;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              req_cin;
    logic              sub_drv;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_sum;
    logic              rsp_cout;
    logic              busy;

    int errors = 0;
    int checks = 0;

    add_seq_ctrl #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADD_SEQ_SUB_EN
        .req_sub   (sub_drv),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
        int                stall;
        logic [DATA_W-1:0] sum;
        logic              cout;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at a negedge; leaves at the negedge after the response handshake.
    task automatic run_op(input string name, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic cin, input logic [DATA_W-1:0] exp_sum, input logic exp_cout,
                          input bit hold, input int stall);
        int n;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        check({name, ".ready_idle"}, {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        else begin
            req_a = DATA_W'($urandom); req_b = DATA_W'($urandom); req_cin = 1'($urandom);
        end
        check({name, ".run_flags"}, {62'd0, busy, req_ready}, 64'b10);
        n = 0;
        while (!rsp_valid && n < 4 * NIB + 8) begin
            @(negedge clk);
            n++;
            if (hold && !rsp_valid) begin
                req_a = DATA_W'($urandom); req_b = DATA_W'($urandom); req_cin = 1'($urandom);
                sub_drv = 1'($urandom);
                rsp_ready = 1'($urandom);
            end
        end
        check({name, ".latency"}, 64'(n), 64'(NIB));
        check({name, ".sum"}, 64'(rsp_sum), 64'(exp_sum));
        check({name, ".cout"}, {63'd0, rsp_cout}, {63'd0, exp_cout});
        rsp_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({name, ".stall_hold"}, {46'd0, rsp_valid, rsp_cout, rsp_sum},
                  {46'd0, 1'b1, exp_cout, exp_sum});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, ".to_idle"}, {61'd0, rsp_valid, req_ready, busy}, 64'b010);
    endtask

    initial begin
        logic [DATA_W:0]   ref_full;
        logic [DATA_W-1:0] ra, rb;
        logic              rc;

        vecs[0] = '{16'h0003, 16'h0005, 1'b0, 0,  16'h0008, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 0,  16'h0000, 1'b1};
        vecs[2] = '{16'h0008, 16'h0007, 1'b1, 10, 16'h0010, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 0,  16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 2,  16'h0000, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 0,  16'h0001, 1'b0};
        vecs[6] = '{16'h00FF, 16'h0F01, 1'b0, 0,  16'h1000, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0;
        sub_drv = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {44'd0, req_ready, rsp_valid, busy, rsp_cout, rsp_sum},
              {44'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_after_reset", {44'd0, req_ready, rsp_valid, busy, rsp_cout, rsp_sum},
                  {44'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        end
        rsp_ready = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].sum, vecs[i].cout, 1'b0, vecs[i].stall);

        // Reset in the second RUN cycle discards the operation.
        req_valid = 1'b1; req_a = 16'h1234; req_b = 16'h1111; req_cin = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset", {44'd0, req_ready, rsp_valid, busy, rsp_cout, rsp_sum},
              {44'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            check("no_stale_valid", {62'd0, rsp_valid, busy}, 64'b00);
        end
        run_op("after_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

`ifdef ADD_SEQ_SUB_EN
        sub_drv = 1'b1;
        run_op("sub_10_1", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b1, 1'b0, 0);
        run_op("sub_1_2", 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0);
        sub_drv = 1'b0;
`endif

        // Back-to-back random ops with req_valid held high throughout.
        for (int i = 0; i < 1000; i++) begin
            ra = DATA_W'($urandom);
            rb = DATA_W'($urandom);
            rc = 1'($urandom);
            sub_drv = 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_drv = 1'($urandom);
`endif
            if (sub_drv) begin
                ref_full[DATA_W-1:0] = ra - rb;
                ref_full[DATA_W]     = (ra >= rb);
            end else begin
                ref_full = (DATA_W + 1)'(ra) + (DATA_W + 1)'(rb) + (DATA_W + 1)'(rc);
            end
            run_op("rand", ra, rb, rc, ref_full[DATA_W-1:0], ref_full[DATA_W], 1'b1, 0);
        end
        req_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
